// File: rtl/ip_ref_loader_if.sv
// ip_ref_loader_if: handshake and RAM-write bundle for the reference loader.
// The slave modport is the loader's view; the master modport is the
// environment's view (command/sample source, RAM, predictor conf FIFO).
interface ip_ref_loader_if #(
  parameter int CONF_W = 20,
  parameter int ADDR_W = 6
);

  // Command channel: configuration word for the next block.
  logic [CONF_W-1:0] cmd_in_rsc_dat;
  logic              cmd_in_rsc_vld;
  logic              cmd_in_rsc_rdy;

  // Byte-serial reference sample channel.
  logic [7:0]        ref_in_rsc_dat;
  logic              ref_in_rsc_vld;
  logic              ref_in_rsc_rdy;

  // Shared write port of the two reference RAMs.
  logic [31:0]       wdata;
  logic [ADDR_W-1:0] wraddress;
  logic              wren;

  // Configuration issued downstream once the block is fully loaded.
  logic [CONF_W-1:0] conf_out_rsc_dat;
  logic              conf_out_rsc_vld;
  logic              conf_out_rsc_rdy;

  modport slave (
    input  cmd_in_rsc_dat, cmd_in_rsc_vld,
    output cmd_in_rsc_rdy,
    input  ref_in_rsc_dat, ref_in_rsc_vld,
    output ref_in_rsc_rdy,
    output wdata, wraddress, wren,
    output conf_out_rsc_dat, conf_out_rsc_vld,
    input  conf_out_rsc_rdy
  );

  modport master (
    output cmd_in_rsc_dat, cmd_in_rsc_vld,
    input  cmd_in_rsc_rdy,
    output ref_in_rsc_dat, ref_in_rsc_vld,
    input  ref_in_rsc_rdy,
    input  wdata, wraddress, wren,
    input  conf_out_rsc_dat, conf_out_rsc_vld,
    output conf_out_rsc_rdy
  );

endinterface

// File: rtl/ip_ref_loader.sv
// ip_ref_loader: writer end of the planar predictor's reference interface.
// Accepts a configuration word, packs 2*(2N+1) byte samples four per word into
// the top-row (base 0) and left-column (base LEFT_BASE) arrays, then issues the
// configuration downstream only after the final word is on the RAM bus.
// Optional build macro: IP_REF_LOADER_PAD_REPLICATE_EN -- when defined, unused
// lanes of a final partial word replicate the last sample; otherwise they are 0.
module ip_ref_loader #(
  parameter int CONF_W    = 20,
  parameter int ADDR_W    = 6,
  parameter int LEFT_BASE = 32
) (
  input  logic           clk,
  input  logic           rst,
  ip_ref_loader_if.slave bus
);

  // Sample index width: the largest array holds 2*32+1 = 65 samples (0..64).
  localparam int K_W = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_TOP,
    S_LOAD_LEFT,
    S_SETTLE,
    S_ISSUE
  } state_e;

  state_e            state_q, state_d;
  logic [K_W-1:0]    k_q, k_d;            // index of the next sample in the array
  logic [K_W-1:0]    k_last_q, k_last_d;  // L-1 = 2N for the current block
  logic [31:0]       pack_q, pack_d;      // lanes already received for this word
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] wraddress_q, wraddress_d;
  logic              wren_q, wren_d;
  logic              cmd_rdy_q, cmd_rdy_d;
  logic              ref_rdy_q, ref_rdy_d;
  logic              conf_vld_q, conf_vld_d;
  logic [CONF_W-1:0] conf_dat_q, conf_dat_d;

  logic              cmd_hs;
  logic              ref_hs;
  logic              conf_hs;
  logic [1:0]        lane;
  logic              last_sample;
  logic              word_done;
  logic [7:0]        pad_byte;
  logic [31:0]       merged;
  logic [ADDR_W-1:0] base;

  // Handshakes use the registered readies, which always track state_q.
  assign cmd_hs      = bus.cmd_in_rsc_vld & cmd_rdy_q;
  assign ref_hs      = bus.ref_in_rsc_vld & ref_rdy_q;
  assign conf_hs     = conf_vld_q & bus.conf_out_rsc_rdy;

  assign lane        = k_q[1:0];
  assign last_sample = (k_q == k_last_q);
  assign word_done   = (lane == 2'd3) | last_sample;
  assign base        = (state_q == S_LOAD_LEFT) ? ADDR_W'(LEFT_BASE) : '0;

`ifdef IP_REF_LOADER_PAD_REPLICATE_EN
  // Edge substitution: lanes past the last sample repeat that sample.
  assign pad_byte = bus.ref_in_rsc_dat;
`else
  assign pad_byte = 8'h00;
`endif

  // Merge the incoming sample into its lane; lanes above it take the pad byte,
  // which later samples overwrite unless this turns out to be the final word.
  always_comb begin
    merged = '0;
    for (int j = 0; j < 4; j++) begin
      if (2'(j) < lane) begin
        merged[8*j +: 8] = pack_q[8*j +: 8];
      end else if (2'(j) == lane) begin
        merged[8*j +: 8] = bus.ref_in_rsc_dat;
      end else begin
        merged[8*j +: 8] = pad_byte;
      end
    end
  end

  // Next-state and next-output computation for the load sequencer.
  always_comb begin
    // NOTE: every _d defaults to its current value first, so no path through
    // the case statement leaves a variable unassigned and no latch is inferred.
    state_d     = state_q;
    k_d         = k_q;
    k_last_d    = k_last_q;
    pack_d      = pack_q;
    wdata_d     = wdata_q;
    wraddress_d = wraddress_q;
    wren_d      = 1'b0;
    conf_dat_d  = conf_dat_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_hs) begin
          conf_dat_d = bus.cmd_in_rsc_dat;
          k_last_d   = K_W'(8) << bus.cmd_in_rsc_dat[1:0];
          k_d        = '0;
          pack_d     = '0;
          state_d    = S_LOAD_TOP;
        end
      end

      S_LOAD_TOP, S_LOAD_LEFT: begin
        if (ref_hs) begin
          pack_d = merged;
          k_d    = k_q + K_W'(1);
          if (word_done) begin
            wdata_d     = merged;
            wraddress_d = base + ADDR_W'(k_q >> 2);
            wren_d      = 1'b1;
          end
          if (last_sample) begin
            k_d     = '0;
            state_d = (state_q == S_LOAD_TOP) ? S_LOAD_LEFT : S_SETTLE;
          end
        end
      end

      // The final left word is on the RAM bus during this cycle.
      S_SETTLE: state_d = S_ISSUE;

      S_ISSUE: begin
        if (conf_hs) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Readies and valid are registered copies of the next state.
    cmd_rdy_d  = (state_d == S_IDLE);
    ref_rdy_d  = (state_d == S_LOAD_TOP) | (state_d == S_LOAD_LEFT);
    conf_vld_d = (state_d == S_ISSUE);
  end

  // Single register stage for state and every output; synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values
    // regardless of statement order.
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      k_last_q    <= '0;
      pack_q      <= '0;
      wdata_q     <= '0;
      wraddress_q <= '0;
      wren_q      <= 1'b0;
      cmd_rdy_q   <= 1'b0;
      ref_rdy_q   <= 1'b0;
      conf_vld_q  <= 1'b0;
      conf_dat_q  <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      k_last_q    <= k_last_d;
      pack_q      <= pack_d;
      wdata_q     <= wdata_d;
      wraddress_q <= wraddress_d;
      wren_q      <= wren_d;
      cmd_rdy_q   <= cmd_rdy_d;
      ref_rdy_q   <= ref_rdy_d;
      conf_vld_q  <= conf_vld_d;
      conf_dat_q  <= conf_dat_d;
    end
  end

  assign bus.cmd_in_rsc_rdy   = cmd_rdy_q;
  assign bus.ref_in_rsc_rdy   = ref_rdy_q;
  assign bus.wdata            = wdata_q;
  assign bus.wraddress        = wraddress_q;
  assign bus.wren             = wren_q;
  assign bus.conf_out_rsc_dat = conf_dat_q;
  assign bus.conf_out_rsc_vld = conf_vld_q;

  // A stalled configuration must stay valid and unchanged.
  conf_hold_a: assert property (@(posedge clk) disable iff (rst)
    (conf_vld_q && !bus.conf_out_rsc_rdy) |=> (conf_vld_q && $stable(conf_dat_q)));

  // RAM writes only happen while loading or in the settle cycle after it.
  wren_window_a: assert property (@(posedge clk) disable iff (rst)
    wren_q |-> (state_q inside {S_LOAD_TOP, S_LOAD_LEFT, S_SETTLE}));

endmodule

// File: tb/tb_ip_ref_loader.sv
// tb_ip_ref_loader: randomized bench for ip_ref_loader. A reference model
// derives the expected RAM writes of each block from the sample list; a
// negedge monitor scores every wren against that queue and checks that the
// write bus holds between writes. Build with IP_REF_LOADER_PAD_REPLICATE_EN
// defined to score the replicate-padding variant.
module tb_ip_ref_loader;

  localparam int CONF_W    = 20;
  localparam int ADDR_W    = 6;
  localparam int LEFT_BASE = 32;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  ip_ref_loader_if #(.CONF_W(CONF_W), .ADDR_W(ADDR_W)) bus ();

  ip_ref_loader #(
    .CONF_W   (CONF_W),
    .ADDR_W   (ADDR_W),
    .LEFT_BASE(LEFT_BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t               exp_q[$];
  logic [31:0]       last_wdata;
  logic [ADDR_W-1:0] last_waddr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drive/observe point for the main thread: just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the RAM write port.
  wr_t e;
  always @(negedge clk) begin
    if (rst) begin
      last_wdata = '0;
      last_waddr = '0;
    end else if (bus.wren) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wren", 32'(bus.wren), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wraddress", 32'(bus.wraddress), 32'(e.addr));
        check("wdata", bus.wdata, e.data);
      end
      last_wdata = bus.wdata;
      last_waddr = bus.wraddress;
    end else begin
      check("wdata_hold", bus.wdata, last_wdata);
      check("wraddress_hold", 32'(bus.wraddress), 32'(last_waddr));
    end
  end

  // Runs one block. abort_after >= 0 pulses rst after that many samples.
  task automatic run_block(input logic [CONF_W-1:0] cmd, input int gap_pct,
                           input int stall, input bit seq_data,
                           input int abort_after, input bit chk_lat);
    int          n_size, l_len, words, total, idx, guard, to, last_i, vld_seen;
    int unsigned hs_cyc;
    logic [7:0]  smp[$];
    logic [7:0]  pad, byte_v;
    logic [31:0] d;
    bit          acc;

    n_size = 4 << cmd[1:0];
    l_len  = 2 * n_size + 1;
    words  = (l_len + 3) / 4;
    total  = (abort_after >= 0) ? abort_after : 2 * l_len;

    smp.delete();
    for (int i = 0; i < 2 * l_len; i++) begin
      smp.push_back(seq_data ? 8'(i) : 8'($urandom));
    end

    // Reference model: array a holds samples a*L .. a*L+L-1, four per word.
    for (int a = 0; a < 2; a++) begin
`ifdef IP_REF_LOADER_PAD_REPLICATE_EN
      pad = smp[a * l_len + l_len - 1];
`else
      pad = 8'h00;
`endif
      for (int w = 0; w < words; w++) begin
        d = '0;
        for (int b = 0; b < 4; b++) begin
          byte_v = (4 * w + b < l_len) ? smp[a * l_len + 4 * w + b] : pad;
          d[8*b +: 8] = byte_v;
        end
        last_i = a * l_len + ((4 * w + 3 < l_len) ? 4 * w + 3 : l_len - 1);
        if (abort_after < 0 || last_i < abort_after) begin
          exp_q.push_back('{addr: ADDR_W'(a * LEFT_BASE + w), data: d});
        end
      end
    end

    // Command handshake.
    bus.cmd_in_rsc_dat = cmd;
    bus.cmd_in_rsc_vld = 1'b1;
    to = 0;
    while (!bus.cmd_in_rsc_rdy && to < 50) begin
      tick();
      to++;
    end
    check("cmd_accept_in_time", 32'(to < 50), 32'd1);
    hs_cyc = cyc;
    tick();
    bus.cmd_in_rsc_vld = 1'b0;
    bus.cmd_in_rsc_dat = CONF_W'($urandom);
    check("cmd_rdy_low_after_hs", 32'(bus.cmd_in_rsc_rdy), 32'd0);

    // Sample stream with optional random vld gaps.
    idx   = 0;
    guard = 0;
    while (idx < total && guard < 5000) begin
      if (gap_pct == 0 || $urandom_range(99) >= gap_pct) begin
        bus.ref_in_rsc_vld = 1'b1;
        bus.ref_in_rsc_dat = smp[idx];
      end else begin
        bus.ref_in_rsc_vld = 1'b0;
        bus.ref_in_rsc_dat = 8'($urandom);
      end
      acc = bus.ref_in_rsc_vld && bus.ref_in_rsc_rdy;
      tick();
      guard++;
      if (acc) idx++;
    end
    bus.ref_in_rsc_vld = 1'b0;
    check("samples_accepted", 32'(idx), 32'(total));

    if (abort_after >= 0) begin
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      vld_seen = 0;
      for (int i = 0; i < 40; i++) begin
        bus.ref_in_rsc_vld = 1'b1;
        bus.ref_in_rsc_dat = 8'($urandom);
        tick();
        if (bus.conf_out_rsc_vld) vld_seen++;
      end
      bus.ref_in_rsc_vld = 1'b0;
      check("abort_no_conf", 32'(vld_seen), 32'd0);
      check("abort_pending_writes", 32'(exp_q.size()), 32'd0);
      check("abort_back_to_idle", 32'(bus.cmd_in_rsc_rdy), 32'd1);
      return;
    end

    // Configuration issue.
    to = 0;
    while (!bus.conf_out_rsc_vld && to < 300) begin
      tick();
      to++;
    end
    check("conf_vld_in_time", 32'(to < 300), 32'd1);
    if (chk_lat) check("conf_latency", cyc - hs_cyc, 32'(2 * l_len + 2));
    check("conf_dat", 32'(bus.conf_out_rsc_dat), 32'(cmd));
    check("writes_before_conf", 32'(exp_q.size()), 32'd0);

    // Backpressure: a second command and extra samples are offered meanwhile.
    for (int i = 0; i < stall; i++) begin
      bus.cmd_in_rsc_vld = 1'b1;
      bus.ref_in_rsc_vld = 1'b1;
      bus.ref_in_rsc_dat = 8'($urandom);
      tick();
      check("stall_conf_vld", 32'(bus.conf_out_rsc_vld), 32'd1);
      check("stall_conf_dat", 32'(bus.conf_out_rsc_dat), 32'(cmd));
      check("stall_ref_rdy", 32'(bus.ref_in_rsc_rdy), 32'd0);
      check("stall_cmd_rdy", 32'(bus.cmd_in_rsc_rdy), 32'd0);
    end
    bus.cmd_in_rsc_vld = 1'b0;
    bus.ref_in_rsc_vld = 1'b0;

    bus.conf_out_rsc_rdy = 1'b1;
    tick();
    bus.conf_out_rsc_rdy = 1'b0;
    check("conf_vld_after_hs", 32'(bus.conf_out_rsc_vld), 32'd0);
    check("cmd_rdy_after_issue", 32'(bus.cmd_in_rsc_rdy), 32'd1);
  endtask

  // Global time bound in case a wait is never satisfied.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1);
  end

  logic [CONF_W-1:0] rcmd;
  int                rgap;

  initial begin
    rst                  = 1'b1;
    bus.cmd_in_rsc_dat   = '0;
    bus.cmd_in_rsc_vld   = 1'b0;
    bus.ref_in_rsc_dat   = '0;
    bus.ref_in_rsc_vld   = 1'b0;
    bus.conf_out_rsc_rdy = 1'b0;

    // Reset: all outputs zero while held, command ready right after release.
    repeat (3) tick();
    check("rst_cmd_rdy", 32'(bus.cmd_in_rsc_rdy), 32'd0);
    check("rst_ref_rdy", 32'(bus.ref_in_rsc_rdy), 32'd0);
    check("rst_wren", 32'(bus.wren), 32'd0);
    check("rst_wdata", bus.wdata, 32'd0);
    check("rst_wraddress", 32'(bus.wraddress), 32'd0);
    check("rst_conf_vld", 32'(bus.conf_out_rsc_vld), 32'd0);
    check("rst_conf_dat", 32'(bus.conf_out_rsc_dat), 32'd0);
    rst = 1'b0;
    tick();
    check("cmd_rdy_after_release", 32'(bus.cmd_in_rsc_rdy), 32'd1);
    check("ref_rdy_after_release", 32'(bus.ref_in_rsc_rdy), 32'd0);

    // N=4, samples 0x00..0x11 back to back.
    run_block(20'h00000, 0, 0, 1'b1, -1, 1'b1);

    // N=32 with random vld gaps.
    run_block(20'hABC03, 30, 2, 1'b0, -1, 1'b0);

    // Random sizes, gaps and short stalls.
    for (int i = 0; i < 8; i++) begin
      rcmd = CONF_W'($urandom);
      rgap = (i % 3 == 0) ? 0 : int'($urandom_range(50));
      run_block(rcmd, rgap, int'($urandom_range(4)), 1'b0, -1, rgap == 0);
    end

    // Ten-cycle conf_out backpressure.
    run_block(20'h5A501, 0, 10, 1'b0, -1, 1'b1);

    // Reset after 5 samples of the LEFT array (L=9), then a clean N=4 block.
    run_block(20'h00000, 0, 0, 1'b1, 9 + 5, 1'b0);
    run_block(20'h00000, 0, 0, 1'b1, -1, 1'b1);

    repeat (3) tick();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
